// File: rtl/gfx_wb_cmd_fifo_if.sv
// Wishbone slave bundle between the management bus and the graphics command FIFO.
interface gfx_wb_cmd_fifo_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      output wbs_ack_o, wbs_dat_o
   );

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      input  wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/gfx_wb_cmd_fifo.sv
// Wishbone-written draw-command FIFO feeding the render pipeline over valid/ready,
// with status/control registers and a watermark/overflow interrupt.
module gfx_wb_cmd_fifo #(
   parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
   parameter int          DEPTH     = 16,
   parameter logic [7:0]  LOW_WM    = 8'd4
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   gfx_wb_cmd_fifo_if.slave   wb,
   output logic               cmd_valid_o,
   output logic [31:0]        cmd_data_o,
   input  logic               cmd_ready_i,
   output logic               irq_o
);
   localparam int         PW      = $clog2(DEPTH);
   localparam logic [7:0] DEPTH_L = 8'(DEPTH);
   localparam logic [1:0] A_CMD = 2'd0, A_STATUS = 2'd1, A_CTRL = 2'd2, A_LOWWM = 2'd3;

   logic          ack_q, ack_d;
   logic [1:0]    adr_q, adr_d;
   logic          we_q, we_d;
   logic [3:0]    sel_q, sel_d;
   logic [31:0]   dat_q, dat_d;
   logic [31:0]   mem_q [DEPTH];
   logic [31:0]   mem_d [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [7:0]    level_q, level_d;
   logic          ovf_q, ovf_d, irq_en_q, irq_en_d, irq_q, irq_d;
   logic [7:0]    lowwm_q, lowwm_d;

   logic          req, push, push_ok, pop, flush, ctrl_wr, lowwm_wr, empty, full;
   logic [31:0]   rd_data;
   logic          unused_adr;

   assign unused_adr = ^wb.wbs_adr_i[1:0];

   always_comb begin
      req      = wb.wbs_stb_i & wb.wbs_cyc_i & (wb.wbs_adr_i[31:4] == ADDR_BASE[31:4]) & ~ack_q;
      ack_d    = req;
      adr_d    = req ? wb.wbs_adr_i[3:2] : adr_q;
      we_d     = req ? wb.wbs_we_i       : we_q;
      sel_d    = req ? wb.wbs_sel_i      : sel_q;
      dat_d    = req ? wb.wbs_dat_i      : dat_q;

      // register side effects use the request captured into the ack cycle
      push     = ack_q & we_q & (adr_q == A_CMD) & (sel_q == 4'hF);
      ctrl_wr  = ack_q & we_q & (adr_q == A_CTRL) & sel_q[0];
      lowwm_wr = ack_q & we_q & (adr_q == A_LOWWM) & sel_q[0];
      flush    = ctrl_wr & dat_q[1];
      empty    = (level_q == 8'd0);
      full     = (level_q == DEPTH_L);
      pop      = ~empty & cmd_ready_i;
      push_ok  = push & (~full | pop);

      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         level_d  = 8'd0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = dat_q;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
         level_d = level_q + {7'd0, push_ok} - {7'd0, pop};
      end

      ovf_d = ovf_q;
      if (ctrl_wr & dat_q[2])
         ovf_d = 1'b0;
      else if (push & full & ~pop)
         ovf_d = 1'b1;

      irq_en_d = ctrl_wr  ? dat_q[0]   : irq_en_q;
      lowwm_d  = lowwm_wr ? dat_q[7:0] : lowwm_q;
      irq_d    = irq_en_q & ((level_q <= lowwm_q) | ovf_q);

      rd_data = 32'd0;
      case (adr_q)
         A_STATUS: rd_data = {20'd0, irq_en_q, ovf_q, full, empty, level_q};
         A_CTRL:   rd_data = {31'd0, irq_en_q};
         A_LOWWM:  rd_data = {24'd0, lowwm_q};
         default:  rd_data = 32'd0;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ack_q    <= 1'b0;
         adr_q    <= 2'd0;
         we_q     <= 1'b0;
         sel_q    <= 4'd0;
         dat_q    <= 32'd0;
         mem_q    <= '{default: '0};
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= 8'd0;
         ovf_q    <= 1'b0;
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
         lowwm_q  <= LOW_WM;
      end else begin
         ack_q    <= ack_d;
         adr_q    <= adr_d;
         we_q     <= we_d;
         sel_q    <= sel_d;
         dat_q    <= dat_d;
         mem_q    <= mem_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
         lowwm_q  <= lowwm_d;
      end
   end

   assign wb.wbs_ack_o = ack_q;
   assign wb.wbs_dat_o = (ack_q & ~we_q) ? rd_data : 32'd0;
   assign cmd_valid_o  = ~empty;
   assign cmd_data_o   = empty ? 32'd0 : mem_q[rd_ptr_q];
   assign irq_o        = irq_q;
endmodule

// File: tb/tb_gfx_wb_cmd_fifo.sv
// Bench for gfx_wb_cmd_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_gfx_wb_cmd_fifo;
   localparam logic [31:0] BASE  = 32'h3000_0000;
   localparam int          DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_ready = 1'b0;
   logic        cmd_valid;
   logic [31:0] cmd_data;
   logic        irq;

   gfx_wb_cmd_fifo_if wb ();

   gfx_wb_cmd_fifo #(.ADDR_BASE(BASE), .DEPTH(DEPTH), .LOW_WM(8'd4)) dut (
      .wb_clk_i   (clk),
      .wb_rst_i   (rst),
      .wb         (wb),
      .cmd_valid_o(cmd_valid),
      .cmd_data_o (cmd_data),
      .cmd_ready_i(cmd_ready),
      .irq_o      (irq)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference model: a plain queue plus the architectural register values
   logic [31:0] q[$];
   bit          ovf_m = 0, irq_en_m = 0, irq_m = 0, ack_m = 0, we_m = 0;
   logic [7:0]  lowwm_m = 8'd4;
   logic [1:0]  a_m = 0;
   logic [3:0]  sel_m = 0;
   logic [31:0] dat_m = 0;
   bit          pop_m, req_m, irq_nx;

   function automatic logic [31:0] rdval(input logic [1:0] a);
      int n;
      n = q.size();
      case (a)
         2'd1: return 32'(n) + ((n == 0) ? 32'd256 : 32'd0) + ((n == DEPTH) ? 32'd512 : 32'd0)
                      + (ovf_m ? 32'd1024 : 32'd0) + (irq_en_m ? 32'd2048 : 32'd0);
         2'd2: return irq_en_m ? 32'd1 : 32'd0;
         2'd3: return 32'(lowwm_m);
         default: return 32'd0;
      endcase
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         ovf_m = 0; irq_en_m = 0; irq_m = 0; ack_m = 0; lowwm_m = 8'd4;
      end else begin
         irq_nx = irq_en_m && ((q.size() <= int'(lowwm_m)) || ovf_m);
         pop_m  = (q.size() != 0) && cmd_ready;
         req_m  = wb.wbs_stb_i && wb.wbs_cyc_i && (wb.wbs_adr_i >= BASE)
                  && (wb.wbs_adr_i < BASE + 32'd16) && !ack_m;
         if (ack_m && we_m && a_m == 2'd2 && sel_m[0] && dat_m[1]) begin
            q.delete();
            pop_m = 0;
         end
         if (pop_m) void'(q.pop_front());
         if (ack_m && we_m) begin
            case (a_m)
               2'd0: if (sel_m == 4'hF) begin
                  if (q.size() < DEPTH) q.push_back(dat_m);
                  else ovf_m = 1;
               end
               2'd2: if (sel_m[0]) begin
                  irq_en_m = dat_m[0];
                  if (dat_m[2]) ovf_m = 0;
               end
               2'd3: if (sel_m[0]) lowwm_m = dat_m[7:0];
               default: ;
            endcase
         end
         irq_m = irq_nx;
         if (req_m) begin
            a_m = wb.wbs_adr_i[3:2]; we_m = wb.wbs_we_i;
            sel_m = wb.wbs_sel_i; dat_m = wb.wbs_dat_i;
         end
         ack_m = req_m;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("ack", {31'd0, wb.wbs_ack_o}, {31'd0, ack_m});
         check("cmd_valid", {31'd0, cmd_valid}, {31'd0, q.size() != 0});
         if (q.size() != 0) check("cmd_data", cmd_data, q[0]);
         check("irq", {31'd0, irq}, {31'd0, irq_m});
         check("rdata", wb.wbs_dat_o, (ack_m && !we_m) ? rdval(a_m) : 32'd0);
      end
   end

   task automatic wb_acc(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input bit pop_on_ack,
                         output logic [31:0] rd, output bit acked, output int lat);
      @(negedge clk);
      wb.wbs_stb_i = 1; wb.wbs_cyc_i = 1; wb.wbs_we_i = we;
      wb.wbs_adr_i = adr; wb.wbs_sel_i = sel; wb.wbs_dat_i = dat;
      acked = 0; rd = 0; lat = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (wb.wbs_ack_o) begin
            acked = 1; lat = i; rd = wb.wbs_dat_o;
            break;
         end
      end
      wb.wbs_stb_i = 0; wb.wbs_cyc_i = 0; wb.wbs_we_i = 0;
      if (acked && pop_on_ack) begin
         cmd_ready = 1;
         @(negedge clk);
         cmd_ready = 0;
      end
   endtask

   logic [31:0] rd;
   bit          ak;
   int          lat;

   task automatic wr(input logic [3:0] off, input logic [31:0] d);
      wb_acc(1, BASE + 32'(off), 4'hF, d, 0, rd, ak, lat);
      check("wr_ack", {31'd0, ak}, 32'd1);
   endtask

   task automatic rd_reg(input logic [3:0] off, input string name, input logic [31:0] exp);
      wb_acc(0, BASE + 32'(off), 4'hF, 32'd0, 0, rd, ak, lat);
      check(name, rd, exp);
   endtask

   logic [31:0] drained [16];
   int          n;

   initial begin
      wb.wbs_stb_i = 0; wb.wbs_cyc_i = 0; wb.wbs_we_i = 0;
      wb.wbs_sel_i = 0; wb.wbs_dat_i = 0; wb.wbs_adr_i = 0;
      repeat (3) @(negedge clk);
      rst = 0;

      // 1: reset state
      check("rst_valid", {31'd0, cmd_valid}, 32'd0);
      check("rst_irq", {31'd0, irq}, 32'd0);
      rd_reg(4'h4, "rst_status", 32'h0000_0100);

      // 2: first push, one-cycle ack and one-cycle head latency
      wb_acc(1, BASE, 4'hF, 32'hA5A5_0001, 0, rd, ak, lat);
      check("push_ack_lat", 32'(lat), 32'd1);
      @(negedge clk);
      check("push_valid", {31'd0, cmd_valid}, 32'd1);
      check("push_head", cmd_data, 32'hA5A5_0001);
      rd_reg(4'h4, "status_lvl1", 32'h0000_0001);

      // 3: overfill by one, then clear overflow
      wr(4'h8, 32'h2);
      for (int i = 1; i <= 17; i++) wr(4'h0, 32'h1000_0000 + 32'(i));
      rd_reg(4'h4, "status_full_ovf", 32'h0000_0610);
      wr(4'h8, 32'h4);
      rd_reg(4'h4, "status_ovf_clr", 32'h0000_0210);

      // 4: push while full with a simultaneous pop, then drain
      wb_acc(1, BASE, 4'hF, 32'hDEAD_BEEF, 1, rd, ak, lat);
      check("full_pushpop_ack", {31'd0, ak}, 32'd1);
      rd_reg(4'h4, "status_still_full", 32'h0000_0210);
      @(negedge clk);
      cmd_ready = 1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (!cmd_valid) break;
         if (n < 16) drained[n] = cmd_data;
         n++;
         @(negedge clk);
      end
      cmd_ready = 0;
      check("drain_count", 32'(n), 32'd16);
      for (int k = 0; k < 15; k++) check("drain_word", drained[k], 32'h1000_0002 + 32'(k));
      check("drain_last", drained[15], 32'hDEAD_BEEF);

      // 5: watermark interrupt timing, then flush with a concurrent pop
      wr(4'h8, 32'h1);
      wr(4'hC, 32'h2);
      for (int i = 1; i <= 4; i++) wr(4'h0, 32'h5000_0000 + 32'(i));
      @(negedge clk);
      @(negedge clk);
      check("irq_above_wm", {31'd0, irq}, 32'd0);
      cmd_ready = 1;
      @(negedge clk);
      @(negedge clk);
      check("wm_head_x3", cmd_data, 32'h5000_0003);
      check("irq_at_wm", {31'd0, irq}, 32'd0);
      @(negedge clk);
      cmd_ready = 0;
      check("wm_head_x4", cmd_data, 32'h5000_0004);
      check("irq_after_wm", {31'd0, irq}, 32'd1);
      wr(4'h0, 32'h5000_0005);
      wr(4'h0, 32'h5000_0006);
      rd_reg(4'h4, "status_three", 32'h0000_0803);
      wb_acc(1, BASE + 32'h8, 4'hF, 32'h3, 1, rd, ak, lat);
      check("flush_valid", {31'd0, cmd_valid}, 32'd0);
      rd_reg(4'h4, "status_flushed", 32'h0000_0900);

      // 6: partial byte select, readback, out-of-window
      wr(4'h0, 32'h6000_0001);
      wb_acc(1, BASE, 4'h3, 32'h0000_0077, 0, rd, ak, lat);
      check("sel3_ack", {31'd0, ak}, 32'd1);
      rd_reg(4'h4, "status_sel3", 32'h0000_0801);
      rd_reg(4'hC, "lowwm_rd", 32'h0000_0002);
      rd_reg(4'h8, "ctrl_rd", 32'h0000_0001);
      rd_reg(4'h0, "cmd_rd", 32'h0000_0000);
      wb_acc(1, BASE + 32'h10, 4'hF, 32'h1234_5678, 0, rd, ak, lat);
      check("oow_wr_noack", {31'd0, ak}, 32'd0);
      wb_acc(0, BASE + 32'h10, 4'hF, 32'd0, 0, rd, ak, lat);
      check("oow_rd_noack", {31'd0, ak}, 32'd0);
      rd_reg(4'h4, "status_final", 32'h0000_0801);

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end
endmodule
